// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle ARM-subset datapath: LDR/STR, ADD/SUB/AND/ORR/MOV/CMP,
// B/BL with condition codes. Unsupported encodings are skipped and latched in a sticky flag.
module multicycle_controller #(
    parameter logic [2:0] SHIFT_NONE = 3'b111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] INSTRUCTION,
    input  logic [3:0]  FLAGS,
    output logic        A3Src,
    output logic        AdrSrc,
    output logic        FlagUpdate,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        WD3Src,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  RegSrc,
    output logic [2:0]  ALUop,
    output logic [2:0]  ShiftType,
    output logic [3:0]  STATE_OUT,
    output logic        ILLEGAL
);

    localparam logic [3:0] StFetch    = 4'd0;
    localparam logic [3:0] StDecode   = 4'd1;
    localparam logic [3:0] StMemAdr   = 4'd2;
    localparam logic [3:0] StMemRead  = 4'd3;
    localparam logic [3:0] StMemWb    = 4'd4;
    localparam logic [3:0] StMemWrite = 4'd5;
    localparam logic [3:0] StExecR    = 4'd6;
    localparam logic [3:0] StExecI    = 4'd7;
    localparam logic [3:0] StAluWb    = 4'd8;
    localparam logic [3:0] StBranch   = 4'd9;

    logic [3:0] state_q, state_d;
    logic       illegal_q, set_illegal;

    logic [3:0] cond;
    logic [1:0] op;
    logic       imm_bit, s_bit, l_br;
    logic [3:0] cmd;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       cond_pass, cmd_valid, is_cmp, is_dp;
    logic [2:0] dp_alu_op;
    logic       unused_instr;

    assign cond    = INSTRUCTION[31:28];
    assign op      = INSTRUCTION[27:26];
    assign imm_bit = INSTRUCTION[25];
    assign cmd     = INSTRUCTION[24:21];
    assign l_br    = INSTRUCTION[24];
    // Bit 20 is S for data-processing and L for memory instructions.
    assign s_bit   = INSTRUCTION[20];
    assign is_dp   = (op == 2'b00);
    assign is_cmp  = (cmd == 4'b1010);
    assign unused_instr = ^INSTRUCTION[19:0];

    assign {flag_n, flag_z, flag_c, flag_v} = FLAGS;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c && !flag_z;
            4'b1001: cond_pass = !flag_c || flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        cmd_valid = 1'b1;
        dp_alu_op = 3'b000;
        case (cmd)
            4'b0100: dp_alu_op = 3'b010;
            4'b0010: dp_alu_op = 3'b001;
            4'b0000: dp_alu_op = 3'b011;
            4'b1100: dp_alu_op = 3'b100;
            4'b1101: dp_alu_op = 3'b101;
            4'b1010: dp_alu_op = 3'b001;
            default: cmd_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = StFetch;
        set_illegal = 1'b0;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                if (cond_pass) begin
                    case (op)
                        2'b01: state_d = StMemAdr;
                        2'b10: state_d = StBranch;
                        2'b00: begin
                            if (!cmd_valid) begin
                                set_illegal = 1'b1;
                            end else begin
                                state_d = imm_bit ? StExecI : StExecR;
                            end
                        end
                        default: set_illegal = 1'b1;
                    endcase
                end
            end
            StMemAdr:  state_d = s_bit ? StMemRead : StMemWrite;
            StMemRead: state_d = StMemWb;
            StExecR,
            StExecI:   state_d = is_cmp ? StFetch : StAluWb;
            default:   state_d = StFetch;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | set_illegal;
        end
    end

    always_comb begin
        A3Src      = 1'b0;
        AdrSrc     = 1'b0;
        FlagUpdate = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        WD3Src     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        RegSrc     = 2'b00;
        ALUop      = 3'b000;
        ShiftType  = SHIFT_NONE;
        STATE_OUT  = 4'd0;
        ILLEGAL    = 1'b0;
        // Holding reset blanks every enable so an aborted instruction cannot commit.
        if (!reset) begin
            STATE_OUT = state_q;
            ILLEGAL   = illegal_q;
            case (state_q)
                StFetch: begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcB   = 2'b11;
                    ResultSrc = 2'b10;
                    RegSrc    = 2'b10;
                end
                StDecode: begin
                    ResultSrc = 2'b10;
                    RegSrc    = is_dp ? 2'b00 : 2'b10;
                end
                StMemAdr: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                end
                StMemRead: begin
                    AdrSrc  = 1'b1;
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                end
                StMemWb: begin
                    AdrSrc    = 1'b1;
                    RegWrite  = 1'b1;
                    ResultSrc = 2'b01;
                end
                StMemWrite: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                    RegSrc   = 2'b10;
                end
                StExecR, StExecI: begin
                    ALUSrcA    = 2'b01;
                    ALUSrcB    = (state_q == StExecI) ? 2'b01 : 2'b00;
                    ALUop      = dp_alu_op;
                    FlagUpdate = s_bit | is_cmp;
                end
                StAluWb: begin
                    RegWrite = 1'b1;
                    ALUop    = dp_alu_op;
                end
                StBranch: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    PCWrite = 1'b1;
                    if (l_br) begin
                        A3Src    = 1'b1;
                        WD3Src   = 1'b1;
                        RegWrite = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class state by state and
// compares state encoding plus the full control word against hand-derived values.
module tb_multicycle_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] INSTRUCTION;
    logic [3:0]  FLAGS;
    logic        A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, RegSrc;
    logic [2:0]  ALUop, ShiftType;
    logic [3:0]  STATE_OUT;
    logic        ILLEGAL;

    int checks = 0;
    int failures = 0;

    multicycle_controller dut (
        .clock      (clock),
        .reset      (reset),
        .INSTRUCTION(INSTRUCTION),
        .FLAGS      (FLAGS),
        .A3Src      (A3Src),
        .AdrSrc     (AdrSrc),
        .FlagUpdate (FlagUpdate),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .WD3Src     (WD3Src),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .RegSrc     (RegSrc),
        .ALUop      (ALUop),
        .ShiftType  (ShiftType),
        .STATE_OUT  (STATE_OUT),
        .ILLEGAL    (ILLEGAL)
    );

    always #5 clock = ~clock;

    logic [21:0] ctl_obs;
    assign ctl_obs = {A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src,
                      ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType};

    // Control word: a3,adr,fu,irw,mw,pcw,rw,wd3, srcA, srcB, resultSrc, regSrc, aluop, shift=111
    function automatic logic [21:0] c(input logic [7:0] en, input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] rs, input logic [1:0] rg,
                                      input logic [2:0] op);
        return {en, sa, sb, rs, rg, op, 3'b111};
    endfunction

    logic [21:0] c_rst, c_fetch, c_dec_dp, c_dec_n, c_memadr, c_memrd, c_memwb, c_memwr;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] st, input logic [21:0] ctl);
        check({tag, "/state"}, {28'd0, STATE_OUT}, {28'd0, st});
        check({tag, "/ctl"}, {10'd0, ctl_obs}, {10'd0, ctl});
    endtask

    initial begin
        c_rst    = c(8'b0000_0000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        c_fetch  = c(8'b0001_0100, 2'b00, 2'b11, 2'b10, 2'b10, 3'b000);
        c_dec_dp = c(8'b0000_0000, 2'b00, 2'b00, 2'b10, 2'b00, 3'b000);
        c_dec_n  = c(8'b0000_0000, 2'b00, 2'b00, 2'b10, 2'b10, 3'b000);
        c_memadr = c(8'b0000_0000, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000);
        c_memrd  = c(8'b0100_0000, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000);
        c_memwb  = c(8'b0100_0010, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000);
        c_memwr  = c(8'b0100_1000, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000);

        reset = 1'b1; INSTRUCTION = 32'h0; FLAGS = 4'h0;
        step(); step();
        chk("reset", 4'd0, c_rst);
        check("reset/ill", {31'd0, ILLEGAL}, 32'd0);

        // op=11 is illegal: DECODE then straight back to FETCH, sticky flag set
        reset = 1'b0; INSTRUCTION = 32'hEC00_0000; #1;
        chk("fetch0", 4'd0, c_fetch);
        step(); chk("ill/dec", 4'd1, c_dec_n);
        step(); chk("ill/back", 4'd0, c_fetch);
        check("ill/set", {31'd0, ILLEGAL}, 32'd1);

        // LDR R1,[R1,#64], reset asserted in MEMWB
        INSTRUCTION = 32'hE591_1040;
        step(); chk("ldr1/dec", 4'd1, c_dec_n);
        step(); chk("ldr1/adr", 4'd2, c_memadr);
        step(); chk("ldr1/rd", 4'd3, c_memrd);
        step(); chk("ldr1/wb", 4'd4, c_memwb);
        check("ill/sticky", {31'd0, ILLEGAL}, 32'd1);
        reset = 1'b1; #1;
        chk("rst_mid", 4'd0, c_rst);
        step(); reset = 1'b0; #1;
        chk("rst_after", 4'd0, c_fetch);
        check("rst_after/ill", {31'd0, ILLEGAL}, 32'd0);

        // LDR R2,[R2,#65]; ADD R0,R1,R2
        INSTRUCTION = 32'hE592_2041;
        step(); chk("ldr2/dec", 4'd1, c_dec_n);
        step(); chk("ldr2/adr", 4'd2, c_memadr);
        step(); chk("ldr2/rd", 4'd3, c_memrd);
        step(); chk("ldr2/wb", 4'd4, c_memwb);
        step(); chk("ldr2/end", 4'd0, c_fetch);
        INSTRUCTION = 32'hE081_0002;
        step(); chk("add/dec", 4'd1, c_dec_dp);
        step(); chk("add/ex", 4'd6, c(8'b0000_0000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b010));
        step(); chk("add/wb", 4'd8, c(8'b0000_0010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010));
        step(); chk("add/end", 4'd0, c_fetch);

        // SUBS R0,R1,R2 then ADDNE with Z=1 (skipped) and Z=0 (taken)
        INSTRUCTION = 32'hE051_0002;
        step(); chk("subs/dec", 4'd1, c_dec_dp);
        step(); chk("subs/ex", 4'd6, c(8'b0010_0000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b001));
        step(); chk("subs/wb", 4'd8, c(8'b0000_0010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001));
        step(); INSTRUCTION = 32'h1081_0002; FLAGS = 4'b0100;
        step(); chk("addne_z/dec", 4'd1, c_dec_dp);
        step(); chk("addne_z/skip", 4'd0, c_fetch);
        FLAGS = 4'b0000;
        step(); step(); chk("addne_nz/ex", 4'd6, c(8'b0000_0000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b010));
        step(); step();

        // STR R1,[R0,#70]
        INSTRUCTION = 32'hE580_1046;
        step(); chk("str/dec", 4'd1, c_dec_n);
        step(); chk("str/adr", 4'd2, c_memadr);
        step(); chk("str/wr", 4'd5, c_memwr);
        step(); chk("str/end", 4'd0, c_fetch);

        // CMP R1,#3: flags updated, no writeback
        INSTRUCTION = 32'hE351_0003;
        step(); step(); chk("cmp/ex", 4'd7, c(8'b0010_0000, 2'b01, 2'b01, 2'b00, 2'b00, 3'b001));
        step(); chk("cmp/end", 4'd0, c_fetch);

        // BL and B
        INSTRUCTION = 32'hEB00_0000;
        step(); chk("bl/dec", 4'd1, c_dec_n);
        step(); chk("bl/br", 4'd9, c(8'b1000_0111, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000));
        step(); chk("bl/end", 4'd0, c_fetch);
        INSTRUCTION = 32'hEA00_0000;
        step(); step(); chk("b/br", 4'd9, c(8'b0000_0100, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000));
        step();

        // Condition boundaries: never, GT fail (N!=V), GE pass (N==V), HI pass, LS fail
        INSTRUCTION = 32'hFA00_0000;
        step(); step(); chk("never/skip", 4'd0, c_fetch);
        check("never/ill", {31'd0, ILLEGAL}, 32'd0);
        INSTRUCTION = 32'hC081_0002; FLAGS = 4'b1000;
        step(); step(); chk("gt/skip", 4'd0, c_fetch);
        INSTRUCTION = 32'hA081_0002; FLAGS = 4'b1001;
        step(); step(); check("ge/take", {28'd0, STATE_OUT}, 32'd6);
        step(); step();
        INSTRUCTION = 32'h8081_0002; FLAGS = 4'b0010;
        step(); step(); check("hi/take", {28'd0, STATE_OUT}, 32'd6);
        step(); step();
        INSTRUCTION = 32'h9081_0002;
        step(); step(); check("ls/skip", {28'd0, STATE_OUT}, 32'd0);
        FLAGS = 4'b0000;

        // MOVS R0,#5 and ORR R0,R1,R2
        INSTRUCTION = 32'hE3B0_0005;
        step(); step(); chk("movs/ex", 4'd7, c(8'b0010_0000, 2'b01, 2'b01, 2'b00, 2'b00, 3'b101));
        step(); chk("movs/wb", 4'd8, c(8'b0000_0010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b101));
        step();
        INSTRUCTION = 32'hE181_0002;
        step(); step(); chk("orr/ex", 4'd6, c(8'b0000_0000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b100));
        step(); step();

        // EOR is unsupported: skipped, flag set and held through a following AND
        INSTRUCTION = 32'hE021_0002;
        step(); chk("eor/dec", 4'd1, c_dec_dp);
        step(); chk("eor/skip", 4'd0, c_fetch);
        check("eor/ill", {31'd0, ILLEGAL}, 32'd1);
        INSTRUCTION = 32'hE001_0002;
        step(); step(); chk("and/ex", 4'd6, c(8'b0000_0000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b011));
        step(); step();
        check("and/ill_held", {31'd0, ILLEGAL}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
